// File: rtl/spi_master_engine.sv
// Mode-0 SPI master: turns one bridge request into a 64-bit cmd/addr/data frame and
// returns read data, a completion pulse and an OKAY/DECERR response.
module spi_master_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                    spi_clk,
    input  logic                    spi_rst_n,
    input  logic [ADDR_WIDTH-1:0]   spi_addr,
    input  logic [DATA_WIDTH-1:0]   spi_wr_data,
    input  logic [DATA_WIDTH/8-1:0] spi_wr_strb,
    input  logic                    spi_wr_valid,
    input  logic                    spi_rd_valid,
    output logic                    spi_ready,
    output logic [DATA_WIDTH-1:0]   spi_rd_data,
    output logic                    spi_rd_done,
    output logic                    spi_wr_done,
    output logic [1:0]              spi_resp,
    output logic                    sclk,
    output logic                    cs_n,
    output logic                    mosi,
    input  logic                    miso
);

    if (DATA_WIDTH != 32) begin : g_bad_dw
        $error("spi_master_engine: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH < 24) begin : g_bad_aw
        $error("spi_master_engine: ADDR_WIDTH must be at least 24");
    end
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("spi_master_engine: CLK_DIV must be in 1..255");
    end

    localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_DONE,
        S_GAP
    } state_t;

    state_t                  state, state_nx;
    logic [63:0]             frame;
    logic [DATA_WIDTH-1:0]   rx_sr;
    logic [5:0]              bit_cnt;
    logic [7:0]              hcnt;
    logic                    is_wr;
    logic                    dec_err;
    logic                    addr_err;
    logic                    accept;
    logic                    half_end;

    // Anything above the 24-bit SPI address space is unreachable on the bus.
    if (ADDR_WIDTH > 24) begin : g_hi
        assign addr_err = |spi_addr[ADDR_WIDTH-1:24];
    end else begin : g_nohi
        assign addr_err = 1'b0;
    end

    assign accept   = spi_ready && (state == S_IDLE) && (spi_wr_valid || spi_rd_valid);
    assign half_end = (hcnt == 8'd0);

    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = addr_err ? S_DONE : S_LOAD;
            S_LOAD:  state_nx = S_SHIFT;
            S_SHIFT: if (half_end && sclk && bit_cnt == 6'd0) state_nx = S_HOLD;
            S_HOLD:  if (half_end) state_nx = S_DONE;
            S_DONE:  state_nx = S_GAP;
            S_GAP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            spi_ready   <= 1'b0;
            spi_rd_data <= '0;
            spi_rd_done <= 1'b0;
            spi_wr_done <= 1'b0;
            spi_resp    <= 2'b00;
            sclk        <= 1'b0;
            cs_n        <= 1'b1;
            mosi        <= 1'b0;
            frame       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            hcnt        <= '0;
            is_wr       <= 1'b0;
            dec_err     <= 1'b0;
        end else begin
            spi_ready   <= (state_nx == S_IDLE);
            spi_rd_done <= 1'b0;
            spi_wr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Write wins a tie; the read valid stays up and is taken next time round.
                        is_wr   <= spi_wr_valid;
                        dec_err <= addr_err;
                        frame   <= spi_wr_valid ? {4'hA, spi_wr_strb, spi_addr[23:0], spi_wr_data}
                                                : {8'h0B, spi_addr[23:0], 32'h0};
                    end
                end
                S_LOAD: begin
                    cs_n    <= 1'b0;
                    mosi    <= frame[63];
                    bit_cnt <= 6'd63;
                    hcnt    <= HALF_RELOAD;
                    sclk    <= 1'b0;
                end
                S_SHIFT: begin
                    if (half_end) begin
                        hcnt <= HALF_RELOAD;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // End of the high phase: sample, fall, and present the next bit.
                            sclk  <= 1'b0;
                            rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                            if (bit_cnt != 6'd0) begin
                                bit_cnt <= bit_cnt - 6'd1;
                                mosi    <= frame[bit_cnt - 6'd1];
                            end
                        end
                    end else begin
                        hcnt <= hcnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (half_end) begin
                        cs_n <= 1'b1;
                        mosi <= 1'b0;
                    end else begin
                        hcnt <= hcnt - 8'd1;
                    end
                end
                S_DONE: begin
                    spi_resp <= dec_err ? 2'b11 : 2'b00;
                    if (is_wr) begin
                        spi_wr_done <= 1'b1;
                    end else begin
                        spi_rd_done <= 1'b1;
                        spi_rd_data <= dec_err ? '0 : rx_sr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
